// File: rtl/data_tcm_banked_pkg.sv
// Shared helpers for the byte-banked data TCM: index widths and the response state record.
package data_tcm_banked_pkg;

  // Width of an index into n entries; never zero so single-entry cases still elaborate.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic vld;
    logic err;
    logic rd;
  } rsp_state_t;

endpackage

// File: rtl/data_tcm_banked_bank.sv
// One LAU-wide bank: single-port RAM with synchronous read; the read register holds when re is low.
module data_tcm_banked_bank
  import data_tcm_banked_pkg::*;
#(
  parameter int LAU   = 8,
  parameter int DEPTH = 1024,
  localparam int AW   = idx_bits(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic           re,
  input  logic [AW-1:0]  addr,
  input  logic [LAU-1:0] wdata,
  output logic [LAU-1:0] rdata
);

  logic [LAU-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_tcm_banked.sv
// Byte-banked data TCM: any-alignment single-cycle access, one-cycle response latency,
// valid/ready on both channels with at most one response outstanding.
module data_tcm_banked
  import data_tcm_banked_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LAU        = 8,
  parameter int SIZE_LAU   = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  localparam int N_BYTES   = DATA_WIDTH / LAU
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [N_BYTES-1:0]    be_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  err_o
);

  localparam int BW    = idx_bits(N_BYTES);
  localparam int OW    = $clog2(SIZE_LAU);
  localparam int DEPTH = SIZE_LAU / N_BYTES;
  // Two extra bits: lane carry past the address space plus headroom for BASE+SIZE.
  localparam int XW    = ADDR_WIDTH + 2;
  localparam logic [XW-1:0] LO = XW'(BASE_ADDR);
  localparam logic [XW-1:0] HI = LO + XW'(SIZE_LAU);

  logic              accept, err, rd_go, wr_go;
  logic [XW-1:0]     lane_addr [N_BYTES];
  logic [OW-1:0]     lane_off  [N_BYTES];
  logic [N_BYTES-1:0] lane_oob;
  logic [BW-1:0]     rot, rsp_rot;
  logic [OW-BW-1:0]  bank_addr [N_BYTES];
  logic [LAU-1:0]    bank_wdat [N_BYTES];
  logic [LAU-1:0]    bank_rdat [N_BYTES];
  logic [N_BYTES-1:0] bank_we;
  rsp_state_t        rsp_q;

  always_comb begin
    for (int i = 0; i < N_BYTES; i++) begin
      lane_addr[i] = XW'(addr_i) + XW'(i);
      lane_oob[i]  = (lane_addr[i] < LO) || (lane_addr[i] >= HI);
      lane_off[i]  = OW'(lane_addr[i] - LO);
    end
  end

  // Writes only range-check the lanes they actually touch.
  assign err    = we_i ? |(lane_oob & be_i) : |lane_oob;
  assign rot    = lane_off[0][BW-1:0];
  assign accept = req_valid_i && req_ready_o;
  assign rd_go  = accept && !we_i && !err;
  assign wr_go  = accept && we_i && !err;

  // Bank b serves the lane whose byte offset lands in it: lane = (b - rot) mod N_BYTES.
  always_comb begin
    logic [BW-1:0] sel;
    sel = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      sel          = BW'(b) - rot;
      bank_addr[b] = lane_off[sel][OW-1:BW];
      bank_wdat[b] = data_i[int'(sel)*LAU +: LAU];
      bank_we[b]   = wr_go && be_i[sel];
    end
  end

  for (genvar b = 0; b < N_BYTES; b++) begin : g_bank
    data_tcm_banked_bank #(
      .LAU   (LAU),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .re    (rd_go),
      .addr  (bank_addr[b]),
      .wdata (bank_wdat[b]),
      .rdata (bank_rdat[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q   <= '0;
      rsp_rot <= '0;
    end else if (accept) begin
      rsp_q.vld <= 1'b1;
      rsp_q.err <= err;
      rsp_q.rd  <= !we_i && !err;
      rsp_rot   <= rot;
    end else if (rsp_ready_i) begin
      rsp_q.vld <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_q.vld;
  assign err_o       = rsp_q.vld && rsp_q.err;
  assign req_ready_o = !rsp_q.vld || rsp_ready_i;

  always_comb begin
    data_o = '0;
    if (rsp_q.vld && rsp_q.rd) begin
      for (int i = 0; i < N_BYTES; i++)
        data_o[i*LAU +: LAU] = bank_rdat[BW'(i) + rsp_rot];
    end
  end

endmodule

// File: tb/tb_data_tcm_banked.sv
// Randomized scoreboard bench for data_tcm_banked against a flat byte-array reference model.
module tb_data_tcm_banked;

  localparam int SIZE = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] data_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] data_o;
  logic        err_o;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [7:0] model [SIZE];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         rdy_mode = 0;

  data_tcm_banked dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .be_i        (be_i),
    .data_i      (data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .data_o      (data_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: every touched byte must fall inside [0, SIZE) using unbounded address arithmetic.
  function automatic rsp_t predict(input logic [31:0] a, input logic w,
                                   input logic [3:0] b, input logic [31:0] d);
    rsp_t r;
    longint unsigned la;
    r.data = '0;
    r.err  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      la = {32'h0, a} + longint'(i);
      if ((!w || b[i]) && la >= SIZE) r.err = 1'b1;
    end
    if (!r.err) begin
      for (int i = 0; i < 4; i++) begin
        la = {32'h0, a} + longint'(i);
        if (w && b[i]) model[int'(la)] = d[i*8 +: 8];
        else if (!w)   r.data[i*8 +: 8] = model[int'(la)];
      end
    end
    return r;
  endfunction

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    bit acc = 1'b0;
    int n = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    addr_i = a; we_i = w; be_i = b; data_i = d;
    while (!acc) begin
      #1;
      acc = req_ready_o;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(predict(a, w, b, d));
      end else begin
        n++;
        if (n > 200) begin
          errors++;
          $display("FAIL issue_timeout: request @%h not accepted after %0d cycles", a, n);
          return;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid_i = 1'b0;
    addr_i = $urandom; we_i = 1'($urandom); be_i = 4'($urandom); data_i = $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 8)
      0:       return $urandom;
      1:       return 32'(SIZE - 4 + int'($urandom % 8));
      default: return 32'($urandom % SIZE);
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0:       rsp_ready_i = 1'b0;
      1:       rsp_ready_i = 1'b1;
      default: rsp_ready_i = ($urandom % 3) != 0;
    endcase
  end

  // Monitor: the model's queue depth defines when a response must be present and what it holds.
  initial forever begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_q.size() != 0));
      chk("req_ready", 32'(req_ready_o), 32'((exp_q.size() == 0) || rsp_ready_i));
      if (rsp_valid_o && exp_q.size() != 0) begin
        chk("rsp_data", data_o, exp_q[0].data);
        chk("rsp_err", 32'(err_o), 32'(exp_q[0].err));
        if (rsp_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int n;
    // Reset while a read response is pending.
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    idle();
    #2;
    chk("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rdy_mode = 1;
    @(negedge clk);
    mon_en = 1'b1;

    for (int w = 0; w < SIZE / 4; w++) issue(32'(w * 4), 1'b1, 4'hF, $urandom);

    issue(32'h10, 1'b1, 4'hF, 32'hA0B0C0D0);
    issue(32'h10, 1'b0, 4'h0, 32'h0);
    issue(32'h21, 1'b1, 4'hF, 32'h44332211);
    issue(32'h20, 1'b0, 4'h0, 32'h0);
    issue(32'h24, 1'b0, 4'h0, 32'h0);
    issue(32'h0,  1'b1, 4'hF, 32'hFFFFFFFF);
    issue(32'h0,  1'b1, 4'b0101, 32'h12345678);
    issue(32'h0,  1'b0, 4'h0, 32'h0);
    issue(32'hFFD, 1'b0, 4'h0, 32'h0);
    issue(32'hFFF, 1'b1, 4'b0001, 32'h000000AB);
    issue(32'hFFF, 1'b1, 4'b0011, 32'h0000CDEF);
    issue(32'hFFC, 1'b0, 4'h0, 32'h0);
    issue(32'hFFFFFFFE, 1'b0, 4'h0, 32'h0);
    issue(32'h40, 1'b1, 4'h0, 32'h55555555);
    idle();

    // Three reads against a stalled response channel, released after four cycles.
    rdy_mode = 0;
    fork
      begin
        issue(32'h10, 1'b0, 4'h0, 32'h0);
        issue(32'h20, 1'b0, 4'h0, 32'h0);
        issue(32'h23, 1'b0, 4'h0, 32'h0);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 1;
      end
    join

    rdy_mode = 2;
    for (int k = 0; k < 700; k++) begin
      if ($urandom % 4 == 0) idle();
      a = rand_addr();
      issue(a, 1'($urandom), 4'($urandom), $urandom);
    end
    idle();

    rdy_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
